// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table, blank pattern, scan FSM states.
// Used by both the display driver and the scan decoder.
package seven_seg_pkg;

  localparam logic [6:0] BLANK_SEGS = 7'h00;

  // Lit-high {g,f,e,d,c,b,a}; entry i is the glyph for hex digit i
  localparam logic [15:0][6:0] GLYPHS = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } scan_state_t;

  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    return GLYPHS[v];
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_glyph.sv
// Combinational reverse lookup of a lit-high segment pattern
// into its hex value, with match and all-dark flags.
module seg_glyph_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] segs,
  output logic [3:0] value,
  output logic       match,
  output logic       blank
);

  always_comb begin
    value = 4'h0;
    match = 1'b0;
    blank = (segs == BLANK_SEGS);
    for (int i = 0; i < 16; i++) begin
      if (segs == GLYPHS[i]) begin
        value = 4'(i);
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Rebuilds four hex digits and dots from multiplexed
// active-low seven-segment anode/cathode lines.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       an3,
  input  logic       an2,
  input  logic       an1,
  input  logic       an0,
  input  logic       ca,
  input  logic       cb,
  input  logic       cc,
  input  logic       cd,
  input  logic       ce,
  input  logic       cf,
  input  logic       cg,
  input  logic       dp,
  output logic [3:0] val3,
  output logic [3:0] val2,
  output logic [3:0] val1,
  output logic [3:0] val0,
  output logic       dot3,
  output logic       dot2,
  output logic       dot1,
  output logic       dot0,
  output logic [3:0] blank,
  output logic       frame_done,
  output logic       seg_err,
  output logic       stale
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic [11:0] raw;
  logic [11:0] sync;

  assign raw = {dp, cg, cf, ce, cd, cc, cb, ca,
                an3, an2, an1, an0};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sync = raw;
    end else begin : g_sync
      for (genvar b = 0; b < 12; b++) begin : g_bit
        logic [SYNC_STAGES-1:0] chain;
        always_ff @(posedge clk) begin
          if (rst) begin
            chain <= '0;
          end else begin
            chain[0] <= raw[b];
            for (int s = 1; s < SYNC_STAGES; s++)
              chain[s] <= chain[s-1];
          end
        end
        assign sync[b] = chain[SYNC_STAGES-1];
      end
    end
  endgenerate

  logic [3:0] an;
  logic [7:0] cath;
  logic [1:0] idx;
  logic       valid;

  assign an   = sync[3:0];
  assign cath = sync[11:4];

  always_comb begin
    idx   = 2'd0;
    valid = 1'b1;
    unique case (1'b1)
      (an == 4'b1110): idx = 2'd0;
      (an == 4'b1101): idx = 2'd1;
      (an == 4'b1011): idx = 2'd2;
      (an == 4'b0111): idx = 2'd3;
      default:         valid = 1'b0;
    endcase
  end

  scan_state_t    state;
  logic [SW-1:0]  scnt;
  logic [TW-1:0]  tcnt;
  logic [1:0]     lat_idx;
  logic [7:0]     lat_cath;
  logic [3:0]     sh_val [4];
  logic [3:0]     sh_dot;
  logic [3:0]     sh_blank;
  logic [3:0]     seen;
  logic [3:0]     vals [4];
  logic [3:0]     dots;

  logic [3:0] dec_val;
  logic       dec_match;
  logic       dec_blank;
  logic       changed;

  seg_glyph_decode u_dec (
    .segs  (~lat_cath[6:0]),
    .value (dec_val),
    .match (dec_match),
    .blank (dec_blank)
  );

  assign changed = (idx != lat_idx) || (cath != lat_cath);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      scnt       <= '0;
      tcnt       <= '0;
      lat_idx    <= 2'd0;
      lat_cath   <= 8'h00;
      sh_dot     <= 4'h0;
      sh_blank   <= 4'h0;
      seen       <= 4'h0;
      dots       <= 4'h0;
      blank      <= 4'h0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      stale      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sh_val[i] <= 4'h0;
        vals[i]   <= 4'h0;
      end
    end else begin
      frame_done <= 1'b0;

      // Frame copy runs one cycle after the completing capture
      if (seen == 4'hF) begin
        for (int i = 0; i < 4; i++)
          vals[i] <= sh_val[i];
        dots       <= sh_dot;
        blank      <= sh_blank;
        frame_done <= 1'b1;
        seen       <= 4'h0;
        stale      <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (valid) begin
            state    <= SETTLE;
            scnt     <= SW'(1);
            lat_idx  <= idx;
            lat_cath <= cath;
            tcnt     <= '0;
          end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TMAX - 1'b1)
              stale <= 1'b1;
          end
        end
        SETTLE: begin
          if (!valid) begin
            state <= IDLE;
          end else if (changed) begin
            scnt     <= SW'(1);
            lat_idx  <= idx;
            lat_cath <= cath;
          end else if (scnt >= SMAX) begin
            state             <= HOLD;
            sh_val[lat_idx]   <= dec_val;
            sh_dot[lat_idx]   <= ~lat_cath[7];
            sh_blank[lat_idx] <= dec_blank & lat_cath[7];
            seen[lat_idx]     <= 1'b1;
            if (!dec_match && !dec_blank)
              seg_err <= 1'b1;
          end else begin
            scnt <= scnt + 1'b1;
          end
        end
        HOLD: begin
          if (!valid) begin
            state <= IDLE;
          end else if (changed) begin
            state    <= SETTLE;
            scnt     <= SW'(1);
            lat_idx  <= idx;
            lat_cath <= cath;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign val3 = vals[3];
  assign val2 = vals[2];
  assign val1 = vals[1];
  assign val0 = vals[0];
  assign dot3 = dots[3];
  assign dot2 = dots[2];
  assign dot1 = dots[1];
  assign dot0 = dots[0];

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: emulates the display driver
// and checks rebuilt frames against a digit-level model.
module tb_seven_seg_scan_decoder;

  localparam int SYNC   = 2;
  localparam int SETTLE = 16;
  localparam int TMO    = 200;
  localparam int LONG   = 30;
  localparam int SHORT  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] an_v  = 4'hF;
  logic [6:0] seg_n = 7'h7F;
  logic       dp_n  = 1'b1;

  logic [3:0] val3, val2, val1, val0;
  logic       dot3, dot2, dot1, dot0;
  logic [3:0] blank;
  logic       frame_done, seg_err, stale;

  logic [3:0] o_val [4];
  logic [3:0] o_dot;

  int errors = 0;
  int checks = 0;
  int frames = 0;
  bit fd_prev = 1'b0;

  logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                          7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C,
                          7'h39, 7'h5E, 7'h79, 7'h71};

  logic [3:0] m_val [4];
  logic [3:0] m_dot, m_blank, m_seen;
  logic [3:0] e_val [4];
  logic [3:0] e_dot, e_blank;
  bit         e_err;
  int         e_frames = 0;

  always #5 clk = ~clk;

  seven_seg_scan_decoder #(
    .SYNC_STAGES    (SYNC),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .an3        (an_v[3]),
    .an2        (an_v[2]),
    .an1        (an_v[1]),
    .an0        (an_v[0]),
    .ca         (seg_n[0]),
    .cb         (seg_n[1]),
    .cc         (seg_n[2]),
    .cd         (seg_n[3]),
    .ce         (seg_n[4]),
    .cf         (seg_n[5]),
    .cg         (seg_n[6]),
    .dp         (dp_n),
    .val3       (val3),
    .val2       (val2),
    .val1       (val1),
    .val0       (val0),
    .dot3       (dot3),
    .dot2       (dot2),
    .dot1       (dot1),
    .dot0       (dot0),
    .blank      (blank),
    .frame_done (frame_done),
    .seg_err    (seg_err),
    .stale      (stale)
  );

  assign o_val[3] = val3;
  assign o_val[2] = val2;
  assign o_val[1] = val1;
  assign o_val[0] = val0;
  assign o_dot    = {dot3, dot2, dot1, dot0};

  always @(negedge clk) begin
    if (frame_done) begin
      frames++;
      checks++;
      if (fd_prev) begin
        errors++;
        $display("FAIL frame_done_width got >1 cycle want 1");
      end
    end
    fd_prev = frame_done;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_val[i] = 4'h0;
      e_val[i] = 4'h0;
    end
    m_dot   = 4'h0;
    m_blank = 4'h0;
    m_seen  = 4'h0;
    e_dot   = 4'h0;
    e_blank = 4'h0;
    e_err   = 1'b0;
  endtask

  // Light one digit for n cycles; a long enough dwell is a capture
  task automatic drive(input int i, input logic [6:0] lit,
                       input logic dl, input int n);
    int k;
    an_v  = ~(4'b0001 << i);
    seg_n = ~lit;
    dp_n  = ~dl;
    tick(n);
    if (n >= SETTLE + SYNC + 2) begin
      k = -1;
      for (int g = 0; g < 16; g++)
        if (gl[g] == lit) k = g;
      m_val[i]   = (k < 0) ? 4'h0 : 4'(k);
      m_dot[i]   = dl;
      m_blank[i] = (lit == 7'h00) && !dl;
      if (k < 0 && lit != 7'h00) e_err = 1'b1;
      m_seen[i]  = 1'b1;
      if (m_seen == 4'hF) begin
        for (int j = 0; j < 4; j++) e_val[j] = m_val[j];
        e_dot   = m_dot;
        e_blank = m_blank;
        m_seen  = 4'h0;
        e_frames++;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] v, input logic [3:0] d);
    for (int i = 3; i >= 0; i--)
      drive(i, gl[v[i*4 +: 4]], d[i], LONG);
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    an_v = 4'hF;
    tick(3);
    rst = 1'b0;
    model_reset();
    tick(1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_val[i] !== 4'h0) begin
        errors++;
        $display("FAIL reset_val%0d got %h want 0", i, o_val[i]);
      end
    end
    checks++;
    if (o_dot !== 4'h0 || blank !== 4'h0) begin
      errors++;
      $display("FAIL reset_dot_blank got %b/%b want 0000/0000", o_dot, blank);
    end
    checks++;
    if ({frame_done, seg_err, stale} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {frame_done, seg_err, stale});
    end
  endtask

  task automatic test_basic();
    send_frame(16'h0123, 4'b0101);
    checks++;
    if (frames !== e_frames) begin
      errors++;
      $display("FAIL basic_frames got %0d want %0d", frames, e_frames);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_val[i] !== 4'(3 - i)) begin
        errors++;
        $display("FAIL basic_val%0d got %h want %h", i, o_val[i], 4'(3 - i));
      end
    end
    checks++;
    if (o_dot !== 4'b0101 || seg_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_dot_err got %b/%b want 0101/0", o_dot, seg_err);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] r;
    for (int v = 0; v < 16; v++) begin
      r = 16'($urandom);
      send_frame({r[15:4], 4'(v)}, r[3:0]);
      checks++;
      if (frames !== e_frames) begin
        errors++;
        $display("FAIL sweep_frames v=%0d got %0d want %0d", v, frames, e_frames);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_val[i] !== e_val[i]) begin
          errors++;
          $display("FAIL sweep_val%0d v=%0d got %h want %h", i, v, o_val[i], e_val[i]);
        end
      end
      checks++;
      if (o_dot !== e_dot || blank !== 4'h0) begin
        errors++;
        $display("FAIL sweep_dot_blank v=%0d got %b/%b want %b/0000", v, o_dot, blank, e_dot);
      end
    end
  endtask

  task automatic test_short_dwell();
    int f0;
    drive(3, gl[$urandom_range(15)], 1'b0, LONG);
    f0 = frames;
    drive(2, 7'h06, 1'b0, SHORT);
    drive(1, gl[$urandom_range(15)], 1'b1, LONG);
    drive(0, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (frames !== f0 || frames !== e_frames) begin
      errors++;
      $display("FAIL short_no_frame got %0d want %0d", frames, f0);
    end
    drive(2, gl[$urandom_range(15)], 1'b1, LONG);
    checks++;
    if (frames !== e_frames) begin
      errors++;
      $display("FAIL short_frames got %0d want %0d", frames, e_frames);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_val[i] !== e_val[i]) begin
        errors++;
        $display("FAIL short_val%0d got %h want %h", i, o_val[i], e_val[i]);
      end
    end
  endtask

  task automatic test_blank_digit();
    drive(3, gl[4'hA], 1'b0, LONG);
    drive(2, 7'h00, 1'b0, LONG);
    drive(1, gl[4'h7], 1'b0, LONG);
    drive(0, gl[4'hE], 1'b1, LONG);
    checks++;
    if (blank !== e_blank || blank !== 4'b0100) begin
      errors++;
      $display("FAIL blank_flags got %b want %b", blank, e_blank);
    end
    checks++;
    if (val2 !== 4'h0 || seg_err !== 1'b0) begin
      errors++;
      $display("FAIL blank_val_err got %h/%b want 0/0", val2, seg_err);
    end
  endtask

  task automatic test_bad_glyph();
    drive(3, gl[$urandom_range(15)], 1'b0, LONG);
    drive(2, gl[$urandom_range(15)], 1'b0, LONG);
    drive(1, 7'h49, 1'b0, 32);
    drive(0, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (seg_err !== 1'b1 || val1 !== 4'h0 || blank[1] !== 1'b0) begin
      errors++;
      $display("FAIL bad_glyph got err=%b val1=%h blank1=%b want 1/0/0",
               seg_err, val1, blank[1]);
    end
    send_frame(16'($urandom), 4'($urandom));
    checks++;
    if (seg_err !== e_err || frames !== e_frames) begin
      errors++;
      $display("FAIL bad_glyph_sticky got err=%b frames=%0d want 1/%0d",
               seg_err, frames, e_frames);
    end
  endtask

  task automatic test_stale();
    an_v = 4'hF;
    tick(TMO / 2);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL stale_early got %b want 0", stale);
    end
    tick(TMO / 2 + 5);
    checks++;
    if (stale !== 1'b1) begin
      errors++;
      $display("FAIL stale_set got %b want 1", stale);
    end
    drive(3, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (stale !== 1'b1) begin
      errors++;
      $display("FAIL stale_hold got %b want 1", stale);
    end
    drive(2, gl[$urandom_range(15)], 1'b0, LONG);
    drive(1, gl[$urandom_range(15)], 1'b0, LONG);
    drive(0, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (stale !== 1'b0 || frames !== e_frames) begin
      errors++;
      $display("FAIL stale_clear got %b frames=%0d want 0/%0d", stale, frames, e_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    drive(3, gl[$urandom_range(15)], 1'b1, LONG);
    drive(2, gl[$urandom_range(15)], 1'b1, LONG);
    drive(1, gl[$urandom_range(15)], 1'b1, LONG);
    f0  = frames;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_val[i] !== 4'h0) begin
        errors++;
        $display("FAIL midrst_val%0d got %h want 0", i, o_val[i]);
      end
    end
    checks++;
    if ({o_dot, blank, frame_done, seg_err, stale} !== 11'h0) begin
      errors++;
      $display("FAIL midrst_flags got %b want 0", {o_dot, blank, frame_done, seg_err, stale});
    end
    drive(0, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (frames !== f0) begin
      errors++;
      $display("FAIL midrst_no_frame got %0d want %0d", frames, f0);
    end
    drive(3, gl[$urandom_range(15)], 1'b0, LONG);
    drive(2, gl[$urandom_range(15)], 1'b1, LONG);
    drive(1, gl[$urandom_range(15)], 1'b0, LONG);
    checks++;
    if (frames !== e_frames || frames !== f0 + 1) begin
      errors++;
      $display("FAIL midrst_frames got %0d want %0d", frames, f0 + 1);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_val[i] !== e_val[i]) begin
        errors++;
        $display("FAIL midrst_val%0d got %h want %h", i, o_val[i], e_val[i]);
      end
    end
    checks++;
    if (o_dot !== e_dot) begin
      errors++;
      $display("FAIL midrst_dot got %b want %b", o_dot, e_dot);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_short_dwell();
    test_blank_digit();
    test_bad_glyph();
    test_stale();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
